// File: rtl/demux_pkg.sv
// Shared lane/word types for the 1-to-4 deserializer and its mux_4_1 partner.
package demux_pkg;

  localparam int LANES_C = 4;
  localparam int SEL_W_C = 2;

  typedef logic [1:0] lane_sel_t;
  typedef logic [3:0] lane_word_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/demux_1_4_deser_lane_counter.sv
// Rotating lane select: wraps 3->0, a sync beat forces it to 1
// (lane 0 has just been written), terminal count flags lane 3.
module lane_counter
  import demux_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_en,
  input  logic      i_load1,
  output lane_sel_t o_sel,
  output logic      o_tc
);

  lane_sel_t r_sel;

  // Select register: clear, load-to-1 on sync, else step when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
    end else if (i_load1) begin
      r_sel <= 2'd1;
    end else if (i_en) begin
      r_sel <= r_sel + 2'd1;
    end
  end

  assign o_sel = r_sel;
  assign o_tc  = (r_sel == 2'd3);

endmodule

// File: rtl/demux_1_4_deser.sv
// Receive end of a time-multiplexed 1-bit link: steers serial bits into
// four lanes and presents each completed word with a valid/ready handshake.
//
// Output register states:
//   state     | meaning
//   OUT_EMPTY | no unconsumed word; data holds the last word
//   OUT_FULL  | data holds a word not yet taken by the consumer
module demux_1_4_deser
  import demux_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SEL_W = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [LANES-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             frame_err
);

  if (LANES != LANES_C || SEL_W != SEL_W_C) begin : g_bad_lanes
    $error("demux_1_4_deser supports only LANES=4, SEL_W=2");
  end

  lane_sel_t  w_sel;
  logic       w_tc;
  logic       w_accept;
  logic       w_sync_beat;
  logic       w_step_beat;
  logic       w_complete;
  out_state_t r_state;
  out_state_t w_state_nxt;
  logic [2:0] r_shadow;
  lane_word_t r_data;
  logic       r_frame_err;

  // Only the completing beat can stall; lanes 0..2 always have room in the shadow.
  assign in_ready    = !((r_state == OUT_FULL) && !out_ready && w_tc);
  assign w_accept    = in_valid && in_ready;
  assign w_sync_beat = w_accept && in_sync;
  assign w_step_beat = w_accept && !in_sync;
  assign w_complete  = w_step_beat && w_tc;

  lane_counter u_lane_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_step_beat),
    .i_load1 (w_sync_beat),
    .o_sel   (w_sel),
    .o_tc    (w_tc)
  );

  // Shadow lanes 0..2 and the sticky framing error; a mid-word sync drops the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= '0;
      r_frame_err <= 1'b0;
    end else if (w_sync_beat) begin
      if (w_sel != 2'd0) begin
        r_shadow    <= {2'b00, in_bit};
        r_frame_err <= 1'b1;
      end else begin
        r_shadow[0] <= in_bit;
      end
    end else if (w_step_beat) begin
      case (w_sel)
        2'd0:    r_shadow[0] <= in_bit;
        2'd1:    r_shadow[1] <= in_bit;
        2'd2:    r_shadow[2] <= in_bit;
        default: ;
      endcase
    end
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next output state: a completion always lands FULL, even while draining.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_complete) w_state_nxt = OUT_FULL;
      OUT_FULL:  if (!w_complete && out_ready) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Word register: loads only on completion, so it holds while unconsumed and after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_complete) begin
      r_data <= {in_bit, r_shadow};
    end
  end

  assign data      = r_data;
  assign out_valid = (r_state == OUT_FULL);
  assign sel       = w_sel;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_demux_1_4_deser.sv
module tb_demux_1_4_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       in_sync;
  logic       in_ready;
  logic [3:0] data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] sel;
  logic       frame_err;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  demux_1_4_deser #(.LANES(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_ready  (in_ready),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted-intended beat; returns 1 time unit after the capturing edge.
  task automatic beat(input logic b, input logic s);
    in_valid = 1'b1;
    in_bit   = b;
    in_sync  = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] k;
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_sync = 1'b0; out_ready = 1'b1;
    idle(); idle();
    rst = 1'b0;
    check("rst_sel", {2'b0, sel}, 4'h0);
    check("rst_data", data, 4'h0);
    check("rst_valid", {3'b0, out_valid}, 4'h0);
    check("rst_ferr", {3'b0, frame_err}, 4'h0);
    check("rst_in_ready", {3'b0, in_ready}, 4'h1);

    // Basic word: 0,1,0,1 -> 4'hA
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    check("basic_sel2", {2'b0, sel}, 4'h2);
    beat(1'b0, 1'b0);
    check("basic_valid_pre", {3'b0, out_valid}, 4'h0);
    beat(1'b1, 1'b0);
    check("basic_data", data, 4'hA);
    check("basic_valid", {3'b0, out_valid}, 4'h1);
    check("basic_sel_wrap", {2'b0, sel}, 4'h0);
    idle();
    check("basic_valid_1cyc", {3'b0, out_valid}, 4'h0);
    check("basic_data_hold", data, 4'hA);

    // Loopback sweep: lane l carries k[l], sync on lane 0, back to back
    for (int w = 0; w < 16; w++) begin
      k = 4'(w);
      for (int l = 0; l < 4; l++) begin
        if (l == 3) check("loop_in_ready", {3'b0, in_ready}, 4'h1);
        beat(k[l], l == 0);
      end
      check("loop_data", data, k);
      check("loop_valid", {3'b0, out_valid}, 4'h1);
    end
    idle();
    check("loop_drain", {3'b0, out_valid}, 4'h0);
    check("loop_ferr", {3'b0, frame_err}, 4'h0);

    // Backpressure: 4'h5 held, 4'h3 stalls on lane 3
    out_ready = 1'b0;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    check("bp_data5", data, 4'h5);
    check("bp_valid5", {3'b0, out_valid}, 4'h1);
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    in_valid = 1'b1; in_bit = 1'b0; in_sync = 1'b0;
    #1;
    check("bp_stall", {3'b0, in_ready}, 4'h0);
    @(posedge clk); #1;
    check("bp_hold_data", data, 4'h5);
    check("bp_hold_sel", {2'b0, sel}, 4'h3);
    check("bp_hold_valid", {3'b0, out_valid}, 4'h1);
    out_ready = 1'b1;
    #1;
    check("bp_release", {3'b0, in_ready}, 4'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_data3", data, 4'h3);
    check("bp_valid3", {3'b0, out_valid}, 4'h1);
    check("bp_sel0", {2'b0, sel}, 4'h0);
    out_ready = 1'b1;
    idle();
    check("bp_drain", {3'b0, out_valid}, 4'h0);
    check("bp_ferr", {3'b0, frame_err}, 4'h0);

    // Mid-word sync: partial 1,1 dropped, then 1,0,0,1 -> 4'h9
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    check("ms_sel2", {2'b0, sel}, 4'h2);
    beat(1'b1, 1'b1);
    check("ms_ferr", {3'b0, frame_err}, 4'h1);
    check("ms_sel1", {2'b0, sel}, 4'h1);
    check("ms_no_out", {3'b0, out_valid}, 4'h0);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    check("ms_no_out2", {3'b0, out_valid}, 4'h0);
    beat(1'b1, 1'b0);
    check("ms_data9", data, 4'h9);
    check("ms_valid", {3'b0, out_valid}, 4'h1);
    check("ms_ferr_sticky", {3'b0, frame_err}, 4'h1);
    idle();

    // Reset with sel==2 and a pending word
    out_ready = 1'b0;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    check("pre_rst_sel", {2'b0, sel}, 4'h2);
    check("pre_rst_valid", {3'b0, out_valid}, 4'h1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mid_rst_sel", {2'b0, sel}, 4'h0);
    check("mid_rst_data", data, 4'h0);
    check("mid_rst_valid", {3'b0, out_valid}, 4'h0);
    check("mid_rst_ferr", {3'b0, frame_err}, 4'h0);
    check("mid_rst_in_ready", {3'b0, in_ready}, 4'h1);
    out_ready = 1'b1;
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    check("post_rst_data", data, 4'hF);
    check("post_rst_valid", {3'b0, out_valid}, 4'h1);

    // Simultaneous drain and completion: F held, then 0,1,1,0 -> 4'h6 with no gap
    out_ready = 1'b0;
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    check("sim_hold_data", data, 4'hF);
    check("sim_hold_valid", {3'b0, out_valid}, 4'h1);
    out_ready = 1'b1;
    beat(1'b0, 1'b0);
    check("sim_valid", {3'b0, out_valid}, 4'h1);
    check("sim_data", data, 4'h6);
    idle();
    check("sim_drain", {3'b0, out_valid}, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
